// File: rtl/imm_pkg.sv
// Shared immediate-format and skid-buffer state encodings for the decode stage.
package imm_pkg;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_Z = 3'd5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/imm_extend.sv
// Combinational immediate select and extension for all RV32I/RV64I formats.
// Latency 0; no flow control.
module imm_extend
  import imm_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 32
) (
  input  logic [31:0]               instr,
  input  logic [2:0]                imm_src,
  output logic [DATA_BUS_WIDTH-1:0] imm,
  output logic                      err
);

  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  // Every signed format carries its sign in instr[31]; Z has a zero MSB, so a
  // single sign-extension of imm32 yields zero-extension for it.
  always_comb begin
    imm32 = '0;
    err   = 1'b0;
    case (imm_src)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z: imm32 = {27'b0, instr[19:15]};
      default: err = 1'b1;
    endcase
  end

  generate
    if (DATA_BUS_WIDTH > 32) begin : g_wide
      assign imm = {{(DATA_BUS_WIDTH-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm = imm32[DATA_BUS_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: one-cycle latency, 1 beat/cycle, skid buffer
// absorbs one extra beat so in_ready is a pure flop with no path from out_ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int TAG_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [2:0]                in_imm_src,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_BUS_WIDTH-1:0] out_imm,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      out_err
);

  typedef struct packed {
    logic [DATA_BUS_WIDTH-1:0] imm;
    logic [TAG_WIDTH-1:0]      tag;
    logic                      err;
  } beat_t;

  beat_t      new_beat;
  beat_t      main_q, main_d;
  beat_t      skid_q, skid_d;
  logic [1:0] state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       accept, drain;

  imm_extend #(
    .DATA_BUS_WIDTH(DATA_BUS_WIDTH)
  ) u_extend (
    .instr  (in_instr),
    .imm_src(in_imm_src),
    .imm    (new_beat.imm),
    .err    (new_beat.err)
  );
  assign new_beat.tag = in_tag;

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = new_beat;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_d = new_beat;
        end else if (accept) begin
          skid_d  = new_beat;
          state_d = ST_TWO;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_imm   = main_q.imm;
  assign out_tag   = main_q.tag;
  assign out_err   = main_q.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: 32- and 64-bit instances share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        r32_in_ready, r32_out_valid, r32_out_err;
  logic [31:0] r32_out_imm;
  logic [7:0]  r32_out_tag;
  logic        r64_in_ready, r64_out_valid, r64_out_err;
  logic [63:0] r64_out_imm;
  logic [7:0]  r64_out_tag;

  always #5 clk = ~clk;

  imm_gen_pipe #(.DATA_BUS_WIDTH(32), .TAG_WIDTH(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(r32_out_valid), .out_ready(out_ready), .out_imm(r32_out_imm),
    .out_tag(r32_out_tag), .out_err(r32_out_err)
  );

  imm_gen_pipe #(.DATA_BUS_WIDTH(64), .TAG_WIDTH(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(r64_out_valid), .out_ready(out_ready), .out_imm(r64_out_imm),
    .out_tag(r64_out_tag), .out_err(r64_out_err)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   done_rand;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference immediates written straight from the ISA field layouts at 64 bits.
  function automatic exp_t model(input logic [31:0] ins, input logic [2:0] src, input logic [7:0] tg);
    exp_t e;
    e.tag = tg;
    e.err = 1'b0;
    case (src)
      3'd0: e.imm = {{52{ins[31]}}, ins[31:20]};
      3'd1: e.imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2: e.imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: e.imm = {{32{ins[31]}}, ins[31:12], 12'b0};
      3'd4: e.imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd5: e.imm = {59'b0, ins[19:15]};
      default: begin
        e.imm = 64'd0;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [7:0] tg,
                      input logic [63:0] eimm, input logic eerr);
    exp_t e;
    e.imm = eimm;
    e.tag = tg;
    e.err = eerr;
    in_valid   = 1'b1;
    in_instr   = ins;
    in_imm_src = src;
    in_tag     = tg;
    for (int w = 0; w < 60; w++) begin
      @(negedge clk);
      if (r32_in_ready) begin
        q32.push_back(e);
        q64.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("accept_in_ready", {63'd0, r32_in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] ins, input logic [2:0] src, input logic [7:0] tg);
    exp_t e;
    e = model(ins, src, tg);
    send(ins, src, tg, e.imm, e.err);
  endtask

  task automatic drain_wait();
    for (int w = 0; w < 40; w++) begin
      if (q32.size() == 0 && q64.size() == 0) break;
      @(negedge clk);
    end
    check("drain_q32_empty", 64'(q32.size()), 64'd0);
    check("drain_q64_empty", 64'(q64.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_ready === 1'b1 && r32_out_valid === 1'b1) begin
      if (q32.size() == 0) begin
        check("dut32_spurious_beat", {63'd0, r32_out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        check("dut32_imm", {32'd0, r32_out_imm}, {32'd0, e.imm[31:0]});
        check("dut32_tag", {56'd0, r32_out_tag}, {56'd0, e.tag});
        check("dut32_err", {63'd0, r32_out_err}, {63'd0, e.err});
      end
    end
    if (rst_n === 1'b1 && out_ready === 1'b1 && r64_out_valid === 1'b1) begin
      if (q64.size() == 0) begin
        check("dut64_spurious_beat", {63'd0, r64_out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = q64.pop_front();
        check("dut64_imm", r64_out_imm, e.imm);
        check("dut64_tag", {56'd0, r64_out_tag}, {56'd0, e.tag});
        check("dut64_err", {63'd0, r64_out_err}, {63'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_instr   = '0;
    in_imm_src = '0;
    in_tag     = '0;
    out_ready  = 1'b1;
    done_rand  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, r32_out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, r32_in_ready}, 64'd0);
    check("rst_out_imm", r64_out_imm, 64'd0);
    check("rst_out_tag", {56'd0, r32_out_tag}, 64'd0);
    check("rst_out_err", {63'd0, r32_out_err}, 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready_before_edge", {63'd0, r32_in_ready}, 64'd0);
    @(negedge clk);
    check("rel_in_ready_after_edge", {63'd0, r32_in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // I-type with a one-cycle latency check
    send(32'hFFC12083, 3'd0, 8'h11, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    @(negedge clk);
    check("lat_out_valid", {63'd0, r32_out_valid}, 64'd1);
    check("lat_out_imm", {32'd0, r32_out_imm}, 64'h0000_0000_FFFF_FFFC);
    @(posedge clk);
    #1;

    t0 = cyc;
    send(32'hFE112E23, 3'd1, 8'h21, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(32'hFE000CE3, 3'd2, 8'h22, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    check("sb_full_rate_cycles", 64'(cyc - t0), 64'd2);
    send(32'h800000B7, 3'd3, 8'h31, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send(32'h000F8073, 3'd5, 8'h32, 64'h0000_0000_0000_001F, 1'b0);
    send(32'hFFFFFFFF, 3'd7, 8'hA5, 64'd0, 1'b1);
    drain_wait();

    // Back-pressure: two beats fill main+skid, third must wait
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(32'h00500093, 3'd0, 8'd1, 64'd5, 1'b0);
    send(32'hFE112E23, 3'd1, 8'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    check("bp_in_ready_low", {63'd0, r32_in_ready}, 64'd0);
    fork
      send(32'h0080006F, 3'd4, 8'd3, 64'd8, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_stall_valid", {63'd0, r32_out_valid}, 64'd1);
          check("bp_stall_tag", {56'd0, r32_out_tag}, 64'd1);
          check("bp_stall_imm", {32'd0, r32_out_imm}, 64'd5);
          check("bp_stall_in_ready", {63'd0, r32_in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain_wait();

    // Random traffic under random back-pressure
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_model($urandom, 3'($urandom_range(0, 7)), 8'($urandom));
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk);
          #2;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain_wait();

    // Reset while holding two beats
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(32'h00100093, 3'd0, 8'h61, 64'd1, 1'b0);
    send(32'h00200093, 3'd0, 8'h62, 64'd2, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'd0, r32_out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, r32_in_ready}, 64'd0);
    check("mid_rst_out_imm", {32'd0, r32_out_imm}, 64'd0);
    check("mid_rst_out_tag", {56'd0, r32_out_tag}, 64'd0);
    check("mid_rst_out_valid64", {63'd0, r64_out_valid}, 64'd0);
    q32.delete();
    q64.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready_before_edge", {63'd0, r32_in_ready}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_stale", {63'd0, r32_out_valid}, 64'd0);
      check("post_rst_in_ready", {63'd0, r32_in_ready}, 64'd1);
    end
    @(posedge clk);
    #1;
    send(32'hFFF00093, 3'd0, 8'h77, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    drain_wait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the pipelined core's decode stage. Accepts a 32-bit instruction word plus a format selector and produces the sign- or zero-extended immediate at DATA_BUS_WIDTH for every RV32I/RV64I immediate format (I, S, B, U, J, CSR-zimm). It has one register stage with a valid/ready handshake and a skid buffer, so it can stall cleanly under back-pressure from execute.

## Interface
- DATA_BUS_WIDTH, 32: output width; legal values 32 or 64.
- TAG_WIDTH, 8: width of the sideband tag carried alongside each beat (e.g. ROB/rd index).
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_instr  in  32  raw instruction word.
- in_imm_src  in  3  format: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 6/7 illegal.
- in_tag  in  TAG_WIDTH  sideband; passed through unchanged.
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  DATA_BUS_WIDTH  extended immediate.
- out_tag  out  TAG_WIDTH  tag of the beat on out_imm.
- out_err  out  1  beat had an illegal imm_src.

## Operation
- Raw immediate formed from in_instr:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Z = instr[19:15].
- Extension:
  - I/S/B/U/J: sign-extend from the MSB of the raw field (instr[31] in all cases) to DATA_BUS_WIDTH. U-type is sign-extended above bit 31 when DATA_BUS_WIDTH=64.
  - Z: zero-extend.
  - Illegal (6/7): out_imm = 0, out_err = 1. The beat still flows and is not dropped.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Storage is one main output register plus one skid register.
  - Main empty, or main draining this cycle: the accepted beat loads main.
  - Main full and stalled: the accepted beat loads skid.
  - Skid full: in_ready = 0. When main drains, skid moves to main the same cycle.
- States: EMPTY (main empty), ONE (main full), TWO (main and skid full).
  - EMPTY→ONE on accept.
  - ONE→ONE on accept+drain.
  - ONE→TWO on accept without drain.
  - ONE→EMPTY on drain without accept.
  - TWO→ONE on drain. No accept is possible in TWO.
- Beats leave in acceptance order; no reordering or duplication.

## Timing
- Latency: accepted at edge N, visible on out_* after edge N (one cycle).
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready is a registered function of state (= state != TWO) and has no combinational path from out_ready.
- out_* remain stable while out_valid && !out_ready.
- Reset (asynchronous, rst_n low, any cycle, including mid-stall):
  - State → EMPTY; all stored beats discarded.
  - out_valid = 0, out_imm = 0, out_tag = 0, out_err = 0.
  - in_ready = 0 while rst_n is low, and 1 from the first clk edge after release.
- Accept and drain in the same cycle in state ONE: the new beat replaces main and state stays ONE.

## Structure
- Shared package imm_pkg:
  - imm_src encoding constants (IMM_I…IMM_Z).
  - State encoding (EMPTY/ONE/TWO).
  - Shared by the control decoder.
- Sub-module imm_extend: combinational format select + extension, parametrised by DATA_BUS_WIDTH, with outputs imm and err. It supersedes the 12-bit-only extender.
- The top contains the skid-buffer FSM and registers.

## Test plan
- I-type: instr 0xFFC12083 (lw x1,-4(x2)), src=0, W=32 → out_imm 0xFFFFFFFC, err 0, one cycle later.
- S-type and B-type back-to-back:
  - 0xFE112E23, src=1 → 0xFFFFFFFC.
  - Then 0xFE000CE3, src=2 → 0xFFFFFFF8.
  - Both at full rate, in order.
- U-type at W=64: 0x800000B7, src=3 → 0xFFFFFFFF80000000. Z-type with instr[19:15]=5'b11111, src=5 → 0x1F.
- Back-pressure:
  - Hold out_ready=0 and push 3 beats (tags 1,2,3).
  - Required: in_ready falls after 2 accepts, and beat 3 waits.
  - Release out_ready: outputs are tags 1,2,3 in order, with out_* stable during the stall.
- Illegal src=7 with instr 0xFFFFFFFF → out_imm 0, out_err 1, tag preserved.
- Reset in state TWO: assert rst_n=0 between edges → out_valid 0 immediately; after release, no stale beat appears and in_ready=1.
